// File: rtl/port_io_pkg.sv
// Shared types and widths for the processor port I/O bridge.
package port_io_pkg;
  localparam int PORT_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } pres_state_t;

  function automatic logic [CNT_W-1:0] to_cnt(input int v);
    return v[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/port_sync_fifo.sv
// Synchronous FIFO, DEPTH a power of two; combinational head on dout.
// Push is ignored when full and pop when empty; push and pop may coincide.
module port_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/port_io_bridge.sv
// Host <-> processor port bridge: queued host bytes are presented on In_port with an
// interrupt pulse each; every Out_port change is queued back to the host (ovf if dropped).
module port_io_bridge
  import port_io_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INT_PULSE   = 1,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [PORT_W-1:0] In_port,
  output logic              intr,
  input  logic [PORT_W-1:0] Out_port,
  input  logic              HLT,
  output logic [PORT_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ovf
);
  localparam logic [CNT_W-1:0] CNT_ONE    = to_cnt(1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = to_cnt(INT_PULSE);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = to_cnt(HOLD_CYCLES);

  pres_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [PORT_W-1:0] prev_out;

  logic              in_push;
  logic              in_pop;
  logic              in_full;
  logic              in_empty;
  logic [PORT_W-1:0] in_head;

  logic              out_push;
  logic              out_pop;
  logic              out_full;
  logic              out_empty;
  logic              out_chg;

  // Held low during reset so the host never sees a full FIFO being cleared.
  assign s_ready = rst && !in_full;
  assign in_push = s_valid && s_ready;
  assign in_pop  = (state == IDLE) && !in_empty && !HLT;

  port_sync_fifo #(
    .W     (PORT_W),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .din   (s_data),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      In_port <= '0;
      intr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_pop) begin
            In_port <= in_head;
            cnt     <= PULSE_LOAD;
            intr    <= 1'b1;
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (cnt <= CNT_ONE) begin
            cnt   <= HOLD_LOAD;
            intr  <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HOLD: begin
          cnt <= cnt - CNT_ONE;
          if (cnt <= CNT_ONE) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

  // Fullness is judged before any same-cycle pop, so a full FIFO drops the change.
  assign out_chg  = (Out_port != prev_out);
  assign out_push = out_chg && !out_full;
  assign m_valid  = !out_empty;
  assign out_pop  = m_valid && m_ready;

  port_sync_fifo #(
    .W     (PORT_W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .din   (Out_port),
    .dout  (m_data),
    .full  (out_full),
    .empty (out_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_out <= '0;
      ovf      <= 1'b0;
    end else begin
      prev_out <= Out_port;
      if (out_chg && out_full) begin
        ovf <= 1'b1;
      end
    end
  end
endmodule
